median3x3_window: RTL and testbench

//   3x3 median engine fed by the line-buffer SRAM controller: accepts one 3-pixel image column
//   (top/mid/bottom rows) per handshake and emits one 8-bit median per column of the image row.

---
 rtl/median3x3_window.sv | 169 ++++++++++++++++
 tb/tb_median3x3_window.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/median3x3_window.sv
// median3x3_window: streaming 3x3 median over 3-row pixel columns.
// Ports: clk, reset (sync, active-high); in_valid/in_ready column handshake
// with in_row_start and in_top/in_mid/in_bot pixels; out_valid/out_data/out_last
// median stream without back-pressure.
module median3x3_window #(
    parameter int WIDTH = 128,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_row_start,
    input  logic [DW-1:0] in_top,
    input  logic [DW-1:0] in_mid,
    input  logic [DW-1:0] in_bot,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t state_q, state_d;

    function automatic logic [DW-1:0] min2(input logic [DW-1:0] x,
                                           input logic [DW-1:0] y);
        return (x < y) ? x : y;
    endfunction

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] x,
                                           input logic [DW-1:0] y);
        return (x < y) ? y : x;
    endfunction

    function automatic logic [DW-1:0] med3(input logic [DW-1:0] x,
                                           input logic [DW-1:0] y,
                                           input logic [DW-1:0] z);
        return max2(min2(x, y), min2(max2(x, y), z));
    endfunction

    // window: index 0 newest, 1 centre, 2 oldest; each column kept sorted
    logic [DW-1:0] w_lo [3];
    logic [DW-1:0] w_md [3];
    logic [DW-1:0] w_hi [3];

    logic [CW-1:0] col_cnt;

    logic          win_v, win_last;
    logic          a_v, a_last;
    logic [DW-1:0] st_a, st_b, st_c;

    logic          accept, start_acc, col_acc, last_acc;

    logic [DW-1:0] l1, h1, m2;
    logic [DW-1:0] s_lo, s_md, s_hi;

    assign in_ready  = ~reset & (state_q != FLUSH);
    assign accept    = in_valid & in_ready;
    assign start_acc = accept & in_row_start;
    // columns without row_start only count once a row is open
    assign col_acc   = accept & ~in_row_start & (state_q == RUN);
    assign last_acc  = col_acc & (col_cnt == LAST_COL);

    // three compare-swaps: lo <= md <= hi
    always_comb begin
        l1   = min2(in_top, in_mid);
        h1   = max2(in_top, in_mid);
        m2   = min2(h1, in_bot);
        s_hi = max2(h1, in_bot);
        s_lo = min2(l1, m2);
        s_md = max2(l1, m2);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_acc) state_d = RUN;
            RUN:     if (last_acc) state_d = FLUSH;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                w_lo[i] <= '0;
                w_md[i] <= '0;
                w_hi[i] <= '0;
            end
            col_cnt   <= '0;
            win_v     <= 1'b0;
            win_last  <= 1'b0;
            a_v       <= 1'b0;
            a_last    <= 1'b0;
            st_a      <= '0;
            st_b      <= '0;
            st_c      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            win_v    <= 1'b0;
            win_last <= 1'b0;
            if (start_acc) begin
                // left padding: centre and oldest are zero columns
                for (int i = 1; i < 3; i++) begin
                    w_lo[i] <= '0;
                    w_md[i] <= '0;
                    w_hi[i] <= '0;
                end
                w_lo[0] <= s_lo;
                w_md[0] <= s_md;
                w_hi[0] <= s_hi;
                col_cnt <= CW'(1);
            end else if (col_acc) begin
                for (int i = 1; i < 3; i++) begin
                    w_lo[i] <= w_lo[i-1];
                    w_md[i] <= w_md[i-1];
                    w_hi[i] <= w_hi[i-1];
                end
                w_lo[0] <= s_lo;
                w_md[0] <= s_md;
                w_hi[0] <= s_hi;
                col_cnt <= last_acc ? '0 : col_cnt + CW'(1);
                win_v   <= 1'b1;
            end else if (state_q == FLUSH) begin
                // right padding: zero column closes the row
                for (int i = 1; i < 3; i++) begin
                    w_lo[i] <= w_lo[i-1];
                    w_md[i] <= w_md[i-1];
                    w_hi[i] <= w_hi[i-1];
                end
                w_lo[0]  <= '0;
                w_md[0]  <= '0;
                w_hi[0]  <= '0;
                win_v    <= 1'b1;
                win_last <= 1'b1;
            end

            a_v    <= win_v;
            a_last <= win_last;
            if (win_v) begin
                st_a <= max2(max2(w_lo[0], w_lo[1]), w_lo[2]);
                st_b <= med3(w_md[0], w_md[1], w_md[2]);
                st_c <= min2(min2(w_hi[0], w_hi[1]), w_hi[2]);
            end

            out_valid <= a_v;
            out_last  <= a_last;
            if (a_v) begin
                out_data <= med3(st_a, st_b, st_c);
            end
        end
    end

endmodule

// File: tb/tb_median3x3_window.sv
// tb_median3x3_window: directed stimulus with a 9-pixel sort model
// checked against the median stream every cycle.
module tb_median3x3_window;

    localparam int WIDTH = 128;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_row_start;
    logic [DW-1:0] in_top, in_mid, in_bot;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;

    median3x3_window #(.WIDTH(WIDTH), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_row_start (in_row_start),
        .in_top       (in_top),
        .in_mid       (in_mid),
        .in_bot       (in_bot),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] d;
        logic       last;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   flush_at = -1;
    int   nv = 0;
    int   nl = 0;
    logic [7:0] log_d [4096];

    function automatic logic [7:0] med9(input logic [23:0] a,
                                        input logic [23:0] b,
                                        input logic [23:0] c);
        logic [7:0] v [9];
        logic [7:0] t;
        for (int i = 0; i < 3; i++) begin
            v[i]   = a[8*i +: 8];
            v[3+i] = b[8*i +: 8];
            v[6+i] = c[8*i +: 8];
        end
        for (int i = 0; i < 9; i++)
            for (int k = 0; k < 8 - i; k++)
                if (v[k] > v[k+1]) begin
                    t = v[k]; v[k] = v[k+1]; v[k+1] = t;
                end
        return v[4];
    endfunction

    // reference model: tracks the open row and queues expected medians
    initial begin
        logic       row_open;
        int         j;
        logic [23:0] wl, wc, wr, col;
        row_open = 1'b0;
        j  = 0;
        wl = '0; wc = '0; wr = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                q.delete();
                row_open = 1'b0;
                flush_at = -1;
            end else if (in_valid && in_ready) begin
                col = {in_top, in_mid, in_bot};
                if (in_row_start) begin
                    row_open = 1'b1;
                    wl = '0; wc = '0; wr = col;
                    j = 1;
                end else if (row_open) begin
                    wl = wc; wc = wr; wr = col;
                    q.push_back('{cyc + 2, med9(wl, wc, wr), 1'b0});
                    if (j == WIDTH - 1) begin
                        q.push_back('{cyc + 3, med9(wc, wr, 24'h0), 1'b1});
                        row_open = 1'b0;
                        flush_at = cyc;
                    end else begin
                        j++;
                    end
                end
            end
        end
    end

    // compare process
    initial begin
        exp_t e;
        logic exp_ready;
        forever begin
            @(negedge clk);
            exp_ready = !reset && (flush_at != cyc);
            total++;
            if (in_ready !== exp_ready) begin
                bad++;
                $display("FAIL in_ready cyc=%0d got=%b want=%b",
                         cyc, in_ready, exp_ready);
            end
            if (out_valid === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_out cyc=%0d got=%h want=none",
                             cyc, out_data);
                end else begin
                    e = q.pop_front();
                    if (e.due != cyc || out_data !== e.d || out_last !== e.last) begin
                        bad++;
                        $display("FAIL median cyc=%0d got=%h/%b want=%h/%b due=%0d",
                                 cyc, out_data, out_last, e.d, e.last, e.due);
                    end
                end
                if (nv < 4096) log_d[nv] = out_data;
                nv++;
                if (out_last) nl++;
            end else begin
                if (q.size() > 0 && q[0].due <= cyc) begin
                    total++;
                    bad++;
                    $display("FAIL missing_out cyc=%0d got=none want=%h", cyc, q[0].d);
                    void'(q.pop_front());
                end
                if (out_last !== 1'b0) begin
                    total++;
                    bad++;
                    $display("FAIL stray_last cyc=%0d got=%b want=0", cyc, out_last);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic send_col(input logic [7:0] t, input logic [7:0] m,
                            input logic [7:0] b, input logic rs);
        int guard;
        in_valid     = 1'b1;
        in_top       = t;
        in_mid       = m;
        in_bot       = b;
        in_row_start = rs;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 8) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout got=%b want=1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid     = 1'b0;
        in_row_start = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] pix(input int kind, input int c, input int lane);
        logic [7:0] t3 [9];
        t3 = '{8'd1, 8'd9, 8'd5, 8'd7, 8'd3, 8'd8, 8'd2, 8'd6, 8'd4};
        case (kind)
            0: return 8'h55;
            1: return (c < 3) ? t3[3*c + lane] : 8'h00;
            2: return (c == 60 && lane == 1) ? 8'hFF : 8'h00;
            default: return 8'((c * 37 + lane * 91 + 13) & 255);
        endcase
    endfunction

    task automatic send_cols(input int kind, input int first, input int n);
        for (int c = first; c < first + n; c++)
            send_col(pix(kind, c, 0), pix(kind, c, 1), pix(kind, c, 2), c == 0);
    endtask

    int base, nl0;

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_row_start = 1'b0;
        in_top = '0; in_mid = '0; in_bot = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("reset_out_valid", out_valid, 0);
            chk("reset_out_data", out_data, 0);
            chk("reset_in_ready", in_ready, 0);
        end
        reset = 1'b0;
        #1;
        chk("ready_after_reset", in_ready, 1);
        idle(2);

        // single window values
        base = nv; nl0 = nl;
        send_cols(1, 0, WIDTH);
        idle(6);
        chk("t3_count", nv - base, WIDTH);
        chk("t3_centre0", log_d[base], 3);
        chk("t3_centre1", log_d[base + 1], 5);
        chk("t3_centre2", log_d[base + 2], 3);
        chk("t3_last", nl - nl0, 1);

        // constant rows back-to-back with in_valid held
        base = nv; nl0 = nl;
        send_cols(0, 0, WIDTH);
        send_cols(0, 0, WIDTH);
        send_cols(3, 0, WIDTH);
        idle(6);
        chk("b2b_count", nv - base, 3 * WIDTH);
        chk("const_first", log_d[base], 8'h55);
        chk("const_last", log_d[base + WIDTH - 1], 8'h55);
        chk("const_row2", log_d[base + WIDTH], 8'h55);
        chk("b2b_lasts", nl - nl0, 3);

        // impulse removal
        base = nv;
        send_cols(2, 0, WIDTH);
        idle(6);
        chk("imp_count", nv - base, WIDTH);
        chk("imp_c59", log_d[base + 59], 0);
        chk("imp_c60", log_d[base + 60], 0);
        chk("imp_c61", log_d[base + 61], 0);

        // row_start at column 40
        base = nv; nl0 = nl;
        send_cols(3, 0, 40);
        send_cols(3, 0, WIDTH);
        idle(6);
        chk("trunc_count", nv - base, 39 + WIDTH);
        chk("trunc_lasts", nl - nl0, 1);

        // reset mid-row, then dropped columns, then a normal row
        send_cols(3, 0, 50);
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("mid_reset_valid", out_valid, 0);
            chk("mid_reset_data", out_data, 0);
            chk("mid_reset_ready", in_ready, 0);
        end
        reset = 1'b0;
        base = nv;
        send_cols(3, 1, 5);
        idle(6);
        chk("idle_drop", nv - base, 0);
        base = nv; nl0 = nl;
        send_cols(3, 0, WIDTH);
        idle(6);
        chk("post_reset_count", nv - base, WIDTH);
        chk("post_reset_last", nl - nl0, 1);
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
